// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared encodings and microword field layout for ctrl_sequencer.
// Field positions are functions of SELW/UADDRW so the layout follows the
// sequencer's parameters.
package ctrl_seq_pkg;

    typedef enum logic [1:0] {
        BR_SEQ  = 2'b00,
        BR_JUMP = 2'b01,
        BR_COND = 2'b10,
        BR_DISP = 2'b11
    } br_mode_e;

    typedef enum logic [1:0] {
        RST_NONE = 2'b00,
        RST_R2   = 2'b01,
        RST_ALL  = 2'b10,
        RST_RSVD = 2'b11
    } rst_code_e;

    typedef enum logic [3:0] {
        F_NXT,
        F_RST,
        F_PC_INC,
        F_R2_INC,
        F_ALU_OP,
        F_ALU_CTRL,
        F_ALU_MUX,
        F_LD_ALU,
        F_RSEL,
        F_WSEL,
        F_INS_RD,
        F_MEM_WR,
        F_MEM_RD,
        F_BR,
        F_SP
    } field_e;

    // Register select values (0 selects nothing)
    localparam int unsigned REG_AR = 1;
    localparam int unsigned REG_DR = 2;
    localparam int unsigned REG_PC = 3;
    localparam int unsigned REG_IR = 4;
    localparam int unsigned REG_R1 = 5;
    localparam int unsigned REG_R2 = 6;
    localparam int unsigned REG_R3 = 7;
    localparam int unsigned REG_R4 = 8;
    localparam int unsigned REG_R5 = 9;
    localparam int unsigned REG_R6 = 10;
    localparam int unsigned REG_R7 = 11;
    localparam int unsigned REG_AC = 12;

    // Bit positions inside the 6-bit ld_alu group
    localparam int unsigned LD_AC  = 0;
    localparam int unsigned LD_R5  = 1;
    localparam int unsigned LD_R1  = 2;
    localparam int unsigned LD_IDY = 3;
    localparam int unsigned LD_IDX = 4;
    localparam int unsigned LD_IR  = 5;

    function automatic int unsigned cw_width(input int unsigned selw, input int unsigned uaddrw);
        return 23 + 2 * selw + uaddrw;
    endfunction

    // LSB position of each microword field, packed MSB->LSB as
    // sp, br_mode, mem_rd, mem_wr, ins_rd, wsel, rsel, ld_alu, alu_mux,
    // alu_ctrl, alu_op, r2_inc, pc_inc, rst_code, nxt
    function automatic int unsigned field_lsb(input field_e f, input int unsigned selw,
                                              input int unsigned uaddrw);
        int unsigned pos;
        pos = 0;
        case (f)
            F_NXT:      pos = 0;
            F_RST:      pos = uaddrw;
            F_PC_INC:   pos = uaddrw + 2;
            F_R2_INC:   pos = uaddrw + 3;
            F_ALU_OP:   pos = uaddrw + 4;
            F_ALU_CTRL: pos = uaddrw + 5;
            F_ALU_MUX:  pos = uaddrw + 8;
            F_LD_ALU:   pos = uaddrw + 11;
            F_RSEL:     pos = uaddrw + 17;
            F_WSEL:     pos = uaddrw + 17 + selw;
            F_INS_RD:   pos = uaddrw + 17 + 2 * selw;
            F_MEM_WR:   pos = uaddrw + 18 + 2 * selw;
            F_MEM_RD:   pos = uaddrw + 19 + 2 * selw;
            F_BR:       pos = uaddrw + 20 + 2 * selw;
            F_SP:       pos = uaddrw + 22 + 2 * selw;
            default:    pos = 0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_sel_decoder.sv
// sel_decoder: register-select to one-hot enable. Select k (1..NREG) sets
// bit k-1; 0 and any value above NREG give an all-zero enable.
module sel_decoder #(
    parameter int unsigned SELW = 4,
    parameter int unsigned NREG = 12
) (
    input  logic [SELW-1:0] sel,
    output logic [NREG-1:0] en
);

    // Compare against every legal select; out-of-range values match nothing
    always_comb begin
        en = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (sel == SELW'(k + 1)) begin
                en[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: microprogram sequencer and control-word register.
// Fetches a microword from an asynchronous ROM each cycle, registers it with
// optional IR select substitution, decodes outputs from the registered word
// and holds on memory handshakes.
// Build option: define CTRL_SEQ_DISPATCH_EN to make br_mode 11 jump to
// disp_addr; otherwise br_mode 11 behaves as a plain jump to nxt.
module ctrl_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned NREG       = 12,
    parameter int unsigned SELW       = 4,
    parameter int unsigned UADDRW     = 5,
    parameter int unsigned RESET_ADDR = 0,
    localparam int unsigned CWW       = 23 + 2 * SELW + UADDRW
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [UADDRW-1:0] rom_addr,
    input  logic [CWW-1:0]    rom_data,
    input  logic [SELW-1:0]   ir_wsel,
    input  logic [SELW-1:0]   ir_rsel,
    input  logic [UADDRW-1:0] disp_addr,
    input  logic              z_flag,
    input  logic              mem_ready,
    output logic              mem_read,
    output logic              mem_wr,
    output logic              ins_read,
    output logic [NREG-1:0]   wr_en,
    output logic [NREG-1:0]   rd_en,
    output logic [5:0]        ld_alu,
    output logic [2:0]        alu_mux,
    output logic [2:0]        alu_ctrl,
    output logic              alu_op,
    output logic              r2_inc,
    output logic              pc_inc,
    output logic              rst_r2,
    output logic              rst_all,
    output logic              stall
);

    localparam int unsigned P_NXT      = field_lsb(F_NXT, SELW, UADDRW);
    localparam int unsigned P_RST      = field_lsb(F_RST, SELW, UADDRW);
    localparam int unsigned P_PC_INC   = field_lsb(F_PC_INC, SELW, UADDRW);
    localparam int unsigned P_R2_INC   = field_lsb(F_R2_INC, SELW, UADDRW);
    localparam int unsigned P_ALU_OP   = field_lsb(F_ALU_OP, SELW, UADDRW);
    localparam int unsigned P_ALU_CTRL = field_lsb(F_ALU_CTRL, SELW, UADDRW);
    localparam int unsigned P_ALU_MUX  = field_lsb(F_ALU_MUX, SELW, UADDRW);
    localparam int unsigned P_LD_ALU   = field_lsb(F_LD_ALU, SELW, UADDRW);
    localparam int unsigned P_RSEL     = field_lsb(F_RSEL, SELW, UADDRW);
    localparam int unsigned P_WSEL     = field_lsb(F_WSEL, SELW, UADDRW);
    localparam int unsigned P_INS_RD   = field_lsb(F_INS_RD, SELW, UADDRW);
    localparam int unsigned P_MEM_WR   = field_lsb(F_MEM_WR, SELW, UADDRW);
    localparam int unsigned P_MEM_RD   = field_lsb(F_MEM_RD, SELW, UADDRW);
    localparam int unsigned P_BR       = field_lsb(F_BR, SELW, UADDRW);
    localparam int unsigned P_SP       = field_lsb(F_SP, SELW, UADDRW);

    logic [UADDRW-1:0] upc;
    logic [UADDRW-1:0] upc_next;
    logic [UADDRW-1:0] upc_seq;
    logic [UADDRW-1:0] rom_nxt;
    logic [CWW-1:0]    cw;
    logic [CWW-1:0]    cw_load;
    br_mode_e          br_mode;
    rst_code_e         rst_code;
    logic              run;
    logic [NREG-1:0]   wr_dec;
    logic [NREG-1:0]   rd_dec;

    // Sequencing/control bits of the executing word are consumed at fetch
    // time from rom_data, so the registered copies are intentionally idle.
    logic unused_cw_bits;
    assign unused_cw_bits = ^{cw[P_SP], cw[P_BR +: 2], cw[P_NXT +: UADDRW]};

`ifndef CTRL_SEQ_DISPATCH_EN
    logic unused_disp;
    assign unused_disp = ^disp_addr;
`endif

    assign rom_addr = upc;
    assign stall    = (cw[P_MEM_RD] | cw[P_MEM_WR]) & ~mem_ready;
    assign run      = ~stall;
    assign br_mode  = br_mode_e'(rom_data[P_BR +: 2]);
    assign rst_code = rst_code_e'(cw[P_RST +: 2]);
    assign rom_nxt  = rom_data[P_NXT +: UADDRW];
    assign upc_seq  = upc + UADDRW'(1);

    // Word to load: ROM word, with IR selects substituted when sp is set
    always_comb begin
        cw_load = rom_data;
        if (rom_data[P_SP]) begin
            cw_load[P_WSEL +: SELW] = ir_wsel;
            cw_load[P_RSEL +: SELW] = ir_rsel;
        end
    end

    // Next micro-address chosen by the branch mode of the word being loaded
    always_comb begin
        upc_next = upc_seq;
        case (br_mode)
            BR_SEQ:  upc_next = upc_seq;
            BR_JUMP: upc_next = rom_nxt;
            BR_COND: upc_next = z_flag ? rom_nxt : upc_seq;
`ifdef CTRL_SEQ_DISPATCH_EN
            BR_DISP: upc_next = disp_addr;
`else
            BR_DISP: upc_next = rom_nxt;
`endif
            default: upc_next = upc_seq;
        endcase
    end

    // Micro-PC and control-word register; a stall freezes both
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upc <= UADDRW'(RESET_ADDR);
            cw  <= '0;
        end else if (run) begin
            upc <= upc_next;
            cw  <= cw_load;
        end
    end

    sel_decoder #(
        .SELW(SELW),
        .NREG(NREG)
    ) u_wr_dec (
        .sel(cw[P_WSEL +: SELW]),
        .en (wr_dec)
    );

    sel_decoder #(
        .SELW(SELW),
        .NREG(NREG)
    ) u_rd_dec (
        .sel(cw[P_RSEL +: SELW]),
        .en (rd_dec)
    );

    // Output decode: levels hold through a stall, strobes fire only in the
    // word's final (unstalled) cycle
    always_comb begin
        mem_read = cw[P_MEM_RD];
        mem_wr   = cw[P_MEM_WR];
        ins_read = cw[P_INS_RD];
        rd_en    = rd_dec;
        alu_mux  = cw[P_ALU_MUX +: 3];
        alu_ctrl = cw[P_ALU_CTRL +: 3];
        wr_en    = run ? wr_dec : '0;
        ld_alu   = run ? cw[P_LD_ALU +: 6] : '0;
        alu_op   = run & cw[P_ALU_OP];
        r2_inc   = run & cw[P_R2_INC];
        pc_inc   = run & cw[P_PC_INC];
        rst_r2   = 1'b0;
        rst_all  = 1'b0;
        case (rst_code)
            RST_R2:  rst_r2 = run;
            RST_ALL: begin
                rst_r2  = run;
                rst_all = run;
            end
            default: begin
                rst_r2  = 1'b0;
                rst_all = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed vector bench for ctrl_sequencer with a small
// microprogram in a behavioural ROM.
module tb_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rom_addr;
    logic [35:0] rom_data;
    logic [3:0]  ir_wsel;
    logic [3:0]  ir_rsel;
    logic [4:0]  disp_addr;
    logic        z_flag;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_wr;
    logic        ins_read;
    logic [11:0] wr_en;
    logic [11:0] rd_en;
    logic [5:0]  ld_alu;
    logic [2:0]  alu_mux;
    logic [2:0]  alu_ctrl;
    logic        alu_op;
    logic        r2_inc;
    logic        pc_inc;
    logic        rst_r2;
    logic        rst_all;
    logic        stall;

    int unsigned n_chk;
    int unsigned n_fail;

    logic [35:0] rom [32];
    assign rom_data = rom[rom_addr];

`ifdef CTRL_SEQ_DISPATCH_EN
    localparam logic [4:0] DISP_EXP = 5'd20;
`else
    localparam logic [4:0] DISP_EXP = 5'd9;
`endif

    ctrl_sequencer #(
        .NREG(12),
        .SELW(4),
        .UADDRW(5),
        .RESET_ADDR(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .ir_wsel(ir_wsel),
        .ir_rsel(ir_rsel),
        .disp_addr(disp_addr),
        .z_flag(z_flag),
        .mem_ready(mem_ready),
        .mem_read(mem_read),
        .mem_wr(mem_wr),
        .ins_read(ins_read),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .ld_alu(ld_alu),
        .alu_mux(alu_mux),
        .alu_ctrl(alu_ctrl),
        .alu_op(alu_op),
        .r2_inc(r2_inc),
        .pc_inc(pc_inc),
        .rst_r2(rst_r2),
        .rst_all(rst_all),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       z;
        logic       rdy;
        logic [3:0] iw;
        logic [3:0] ir;
        logic [4:0]  ra;
        logic        st;
        logic [11:0] wr;
        logic [11:0] rd;
        logic [2:0]  mem;   // {mem_read, mem_wr, ins_read}
        logic [5:0]  ld;
        logic [2:0]  mux;
        logic [2:0]  ctl;
        logic [4:0]  strb;  // {alu_op, r2_inc, pc_inc, rst_r2, rst_all}
    } vec_t;

    vec_t vecs [17];

    function automatic logic [35:0] mkw(
        input logic sp, input logic [1:0] br, input logic mrd, input logic mwr,
        input logic ird, input logic [3:0] ws, input logic [3:0] rs,
        input logic [5:0] ld, input logic [2:0] mux, input logic [2:0] ctl,
        input logic op, input logic r2, input logic pc, input logic [1:0] rc,
        input logic [4:0] nxt);
        return {sp, br, mrd, mwr, ird, ws, rs, ld, mux, ctl, op, r2, pc, rc, nxt};
    endfunction

    function automatic vec_t mkv(
        input logic rn, input logic z, input logic rdy, input logic [3:0] iw,
        input logic [3:0] ir, input logic [4:0] ra, input logic st,
        input logic [11:0] wr, input logic [11:0] rd, input logic [2:0] mem,
        input logic [5:0] ld, input logic [2:0] mux, input logic [2:0] ctl,
        input logic [4:0] strb);
        vec_t v;
        v.rst_n = rn; v.z = z; v.rdy = rdy; v.iw = iw; v.ir = ir;
        v.ra = ra; v.st = st; v.wr = wr; v.rd = rd; v.mem = mem;
        v.ld = ld; v.mux = mux; v.ctl = ctl; v.strb = strb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " rom_addr"}, 64'(rom_addr), 64'd0);
        chk({tag, " stall"}, 64'(stall), 64'd0);
        chk({tag, " outputs"},
            64'({mem_read, mem_wr, ins_read, wr_en, rd_en, ld_alu, alu_mux, alu_ctrl,
                 alu_op, r2_inc, pc_inc, rst_r2, rst_all}), 64'd0);
    endtask

    initial begin
        bit found;
        n_chk  = 0;
        n_fail = 0;

        for (int i = 0; i < 32; i++) rom[i] = '0;
        //            sp br   mrd mwr ird ws  rs  ld        mux ctl op r2 pc rc     nxt
        rom[0]  = mkw(0, 2'd0, 0, 0, 0, 1,  2,  6'b000001, 1, 0, 0, 0, 0, 2'b00, 0);
        rom[1]  = mkw(0, 2'd2, 0, 0, 0, 12, 0,  6'b100000, 0, 2, 0, 0, 0, 2'b00, 7);
        rom[2]  = mkw(1, 2'd0, 0, 0, 0, 3,  5,  6'b000000, 0, 0, 0, 0, 0, 2'b00, 0);
        rom[3]  = mkw(1, 2'd0, 0, 0, 0, 4,  4,  6'b000000, 0, 0, 0, 0, 0, 2'b00, 0);
        rom[4]  = mkw(0, 2'd0, 1, 0, 0, 2,  1,  6'b000000, 0, 0, 0, 0, 1, 2'b01, 0);
        rom[5]  = mkw(0, 2'd3, 0, 1, 1, 0,  0,  6'b000000, 0, 0, 1, 1, 0, 2'b10, 9);
        rom[7]  = mkw(0, 2'd1, 0, 0, 0, 0,  3,  6'b000000, 0, 0, 1, 0, 0, 2'b00, 1);
        rom[9]  = mkw(0, 2'd1, 0, 0, 0, 0,  0,  6'b000000, 0, 5, 0, 0, 0, 2'b11, 31);
        rom[20] = mkw(0, 2'd1, 0, 0, 0, 0,  0,  6'b000000, 0, 5, 0, 0, 0, 2'b11, 31);
        rom[31] = mkw(0, 2'd0, 0, 0, 0, 0,  0,  6'b010000, 7, 0, 0, 0, 0, 2'b00, 0);

        //              rn z  rdy iw  ir  ra  st wr       rd       mem     ld     mux ctl strb
        vecs[0]  = mkv(0, 1, 1, 0,  0,  0,  0, 12'h000, 12'h000, 3'b000, 6'h00, 0, 0, 5'b00000);
        vecs[1]  = mkv(1, 0, 1, 0,  0,  0,  0, 12'h000, 12'h000, 3'b000, 6'h00, 0, 0, 5'b00000);
        vecs[2]  = mkv(1, 1, 1, 0,  0,  1,  0, 12'h001, 12'h002, 3'b000, 6'h01, 1, 0, 5'b00000);
        vecs[3]  = mkv(1, 0, 1, 0,  0,  7,  0, 12'h800, 12'h000, 3'b000, 6'h20, 0, 2, 5'b00000);
        vecs[4]  = mkv(1, 0, 1, 0,  0,  1,  0, 12'h000, 12'h004, 3'b000, 6'h00, 0, 0, 5'b10000);
        vecs[5]  = mkv(1, 0, 1, 6,  13, 2,  0, 12'h800, 12'h000, 3'b000, 6'h20, 0, 2, 5'b00000);
        vecs[6]  = mkv(1, 0, 1, 13, 12, 3,  0, 12'h020, 12'h000, 3'b000, 6'h00, 0, 0, 5'b00000);
        vecs[7]  = mkv(1, 0, 0, 0,  0,  4,  0, 12'h000, 12'h800, 3'b000, 6'h00, 0, 0, 5'b00000);
        vecs[8]  = mkv(1, 0, 0, 0,  0,  5,  1, 12'h000, 12'h001, 3'b100, 6'h00, 0, 0, 5'b00000);
        vecs[9]  = mkv(1, 0, 0, 0,  0,  5,  1, 12'h000, 12'h001, 3'b100, 6'h00, 0, 0, 5'b00000);
        vecs[10] = mkv(1, 0, 0, 0,  0,  5,  1, 12'h000, 12'h001, 3'b100, 6'h00, 0, 0, 5'b00000);
        vecs[11] = mkv(1, 0, 1, 0,  0,  5,  0, 12'h002, 12'h001, 3'b100, 6'h00, 0, 0, 5'b00110);
        vecs[12] = mkv(1, 0, 1, 0,  0,  DISP_EXP, 0, 12'h000, 12'h000, 3'b011, 6'h00, 0, 0, 5'b11011);
        vecs[13] = mkv(1, 0, 1, 0,  0,  31, 0, 12'h000, 12'h000, 3'b000, 6'h00, 0, 5, 5'b00000);
        vecs[14] = mkv(1, 0, 1, 0,  0,  0,  0, 12'h000, 12'h000, 3'b000, 6'h10, 7, 0, 5'b00000);
        vecs[15] = mkv(1, 0, 1, 0,  0,  1,  0, 12'h001, 12'h002, 3'b000, 6'h01, 1, 0, 5'b00000);
        vecs[16] = mkv(1, 0, 1, 0,  0,  2,  0, 12'h800, 12'h000, 3'b000, 6'h20, 0, 2, 5'b00000);

        rst_n     = 1'b0;
        z_flag    = 1'b0;
        mem_ready = 1'b1;
        ir_wsel   = '0;
        ir_rsel   = '0;
        disp_addr = 5'd20;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst_n     = vecs[i].rst_n;
            z_flag    = vecs[i].z;
            mem_ready = vecs[i].rdy;
            ir_wsel   = vecs[i].iw;
            ir_rsel   = vecs[i].ir;
            #1;
            chk($sformatf("v%0d rom_addr", i), 64'(rom_addr), 64'(vecs[i].ra));
            chk($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].st));
            chk($sformatf("v%0d wr_en", i), 64'(wr_en), 64'(vecs[i].wr));
            chk($sformatf("v%0d rd_en", i), 64'(rd_en), 64'(vecs[i].rd));
            chk($sformatf("v%0d mem", i), 64'({mem_read, mem_wr, ins_read}), 64'(vecs[i].mem));
            chk($sformatf("v%0d ld_alu", i), 64'(ld_alu), 64'(vecs[i].ld));
            chk($sformatf("v%0d alu_mux_ctrl", i), 64'({alu_mux, alu_ctrl}),
                64'({vecs[i].mux, vecs[i].ctl}));
            chk($sformatf("v%0d strobes", i), 64'({alu_op, r2_inc, pc_inc, rst_r2, rst_all}),
                64'(vecs[i].strb));
        end

        // Reset asserted in the middle of a memory stall
        ir_wsel = '0;
        ir_rsel = '0;
        found   = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            mem_ready = 1'b0;
            #1;
            if (stall === 1'b1) found = 1'b1;
        end
        chk("midstall reached", 64'(found), 64'd1);
        chk("midstall rom_addr", 64'(rom_addr), 64'd5);
        chk("midstall mem_read", 64'(mem_read), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("midstall reset");

        // First word after reset release
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("release rom_addr", 64'(rom_addr), 64'd1);
        chk("release wr_en", 64'(wr_en), 64'h001);
        chk("release ld_alu", 64'(ld_alu), 64'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time limit so the bench cannot hang
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
